// File: rtl/fifo_reader_if.sv
// rtl/fifo_reader_if.sv - FIFO read port plus downstream valid/ready stream for fifo_reader
interface fifo_reader_if #(
   parameter int FIFO_WIDTH = 16
);
   logic                  fifo_empty;
   logic                  fifo_underflow;
   logic [FIFO_WIDTH-1:0] fifo_dout;
   logic                  fifo_rd_en;
   logic [FIFO_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;

   modport master (
      input  fifo_empty, fifo_underflow, fifo_dout, m_ready,
      output fifo_rd_en, m_data, m_valid
   );

   modport slave (
      output fifo_empty, fifo_underflow, fifo_dout, m_ready,
      input  fifo_rd_en, m_data, m_valid
   );
endinterface

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO drain controller with 2-entry skid buffer; FIFO_READER_CHECK_EN enables underflow check
module fifo_reader #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   fifo_reader_if.master        bus,
   output logic [CNT_WIDTH-1:0] rd_count,
   output logic                 underflow_err
);
   logic [1:0]            occ;
   logic [1:0]            occ_next;
   logic [1:0]            fill_after_pop;
   logic [1:0]            tail_idx;
   logic                  pend;
   logic                  pop;
   logic                  push;
   logic                  uf_hit;
   logic                  rd_en;
   logic [FIFO_WIDTH-1:0] slot0;
   logic [FIFO_WIDTH-1:0] slot1;

`ifdef FIFO_READER_CHECK_EN
   assign uf_hit = pend && bus.fifo_underflow;
`else
   logic unused_underflow;
   assign unused_underflow = bus.fifo_underflow;
   assign uf_hit           = 1'b0;
`endif

   always_comb begin
      pop            = (occ != 2'd0) && bus.m_ready;
      push           = pend && !uf_hit;
      // occ + pend never exceeds 2, so 2 bits hold every intermediate value
      fill_after_pop = occ + {1'b0, pend} - {1'b0, pop};
      tail_idx       = occ - {1'b0, pop};
      occ_next       = occ + {1'b0, push} - {1'b0, pop};
      rd_en          = rst_n && enable && !bus.fifo_empty && (fill_after_pop < 2'd2);
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = (occ != 2'd0);
   assign bus.m_data     = slot0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ      <= 2'd0;
         pend     <= 1'b0;
         slot0    <= '0;
         slot1    <= '0;
         rd_count <= '0;
      end else begin
         occ      <= occ_next;
         pend     <= rd_en;
         rd_count <= rd_count + {{(CNT_WIDTH-1){1'b0}}, pop};
         if (pop && occ == 2'd2)
            slot0 <= slot1;
         // the tail slot is chosen after the head advances, so a shift and a write can coexist
         if (push) begin
            if (tail_idx == 2'd0)
               slot0 <= bus.fifo_dout;
            else
               slot1 <= bus.fifo_dout;
         end
      end
   end

`ifdef FIFO_READER_CHECK_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         underflow_err <= 1'b0;
      else if (uf_hit)
         underflow_err <= 1'b1;
   end
`else
   assign underflow_err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - directed scoreboard bench for fifo_reader against a behavioral FIFO
module tb_fifo_reader;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [15:0]   rd_count;
   logic          underflow_err;
   logic          uf_force;
   logic          ready;

   logic [W-1:0]  mem [0:255];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   logic [W-1:0]  model_dout = '0;

   logic [W-1:0]  exp_q [$];
   int            n_assert = 0;
   int            n_fail = 0;
   int            n_pop = 0;
   logic [W-1:0]  exp_w;
   logic [W-1:0]  held;
   int            base;
   int            guard;

   fifo_reader_if #(.FIFO_WIDTH(W)) bus ();

   assign bus.fifo_empty     = (rd_ptr == wr_ptr);
   assign bus.fifo_dout      = model_dout;
   assign bus.fifo_underflow = uf_force;
   assign bus.m_ready        = ready;

   fifo_reader #(.FIFO_WIDTH(W), .CNT_WIDTH(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .bus           (bus),
      .rd_count      (rd_count),
      .underflow_err (underflow_err)
   );

   always #5 clk = ~clk;

   // behavioral FIFO: one-cycle read latency, not affected by the reader's reset
   always @(posedge clk) begin
      if (bus.fifo_rd_en && (rd_ptr != wr_ptr)) begin
         model_dout <= mem[rd_ptr];
         rd_ptr     <= rd_ptr + 1;
      end
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic push_word(input logic [W-1:0] w);
      mem[wr_ptr] = w;
      wr_ptr      = wr_ptr + 1;
      exp_q.push_back(w);
   endtask

   task automatic tick();
      #1;
      chk("rd_en_while_empty", W'(bus.fifo_rd_en && bus.fifo_empty), W'(0));
      if (rst_n && bus.m_valid && ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", bus.m_data, W'(16'hDEAD));
         end else begin
            exp_w = exp_q.pop_front();
            chk("word_order", bus.m_data, exp_w);
         end
         n_pop++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      guard = 0;
      while (exp_q.size() != 0 && guard < budget) begin
         tick();
         guard++;
      end
      chk("drain_timeout", W'(exp_q.size()), W'(0));
   endtask

   initial begin
      rst_n    = 1'b0;
      enable   = 1'b1;
      uf_force = 1'b0;
      ready    = 1'b1;
      @(negedge clk);

      // reset held two cycles with a non-empty FIFO
      push_word(16'hA5A5);
      #1 chk("rst_rd_en_0", W'(bus.fifo_rd_en), W'(0));
      tick();
      chk("rst_rd_en_1", W'(bus.fifo_rd_en), W'(0));
      tick();
      rst_n = 1'b1;
      #1;
      chk("rst_m_valid", W'(bus.m_valid), W'(0));
      chk("rst_m_data", bus.m_data, W'(0));
      chk("rst_rd_count", rd_count, W'(0));
      chk("rst_uf_err", W'(underflow_err), W'(0));

      // single word: rd_en in N, m_valid in N+2
      chk("single_rd_en_N", W'(bus.fifo_rd_en), W'(1));
      tick();
      chk("single_valid_N1", W'(bus.m_valid), W'(0));
      tick();
      chk("single_valid_N2", W'(bus.m_valid), W'(1));
      chk("single_data_N2", bus.m_data, W'(16'hA5A5));
      tick();
      chk("single_rd_count", rd_count, W'(1));

      // burst of 8 at full rate
      for (int i = 1; i <= 8; i++) push_word(W'(i));
      base = n_pop;
      drain(40);
      tick();
      tick();
      chk("burst_rd_en_idle", W'(bus.fifo_rd_en), W'(0));
      chk("burst_empty", W'(bus.fifo_empty), W'(1));
      chk("burst_pops", W'(n_pop - base), W'(8));
      chk("burst_rd_count", rd_count, W'(9));

      // backpressure for 5 cycles in the middle of a burst
      for (int i = 1; i <= 8; i++) push_word(W'(16'h0010 + i));
      tick();
      tick();
      tick();
      ready = 1'b0;
      tick();
      tick();
      held = bus.m_data;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_rd_en_low", W'(bus.fifo_rd_en), W'(0));
         chk("bp_valid", W'(bus.m_valid), W'(1));
         chk("bp_data_stable", bus.m_data, held);
         tick();
      end
      ready = 1'b1;
      drain(40);
      chk("bp_rd_count", rd_count, W'(17));

      // reset after three words of a burst
      for (int i = 1; i <= 8; i++) push_word(W'(16'h0020 + i));
      base  = n_pop;
      guard = 0;
      while (n_pop - base < 3 && guard < 30) begin
         tick();
         guard++;
      end
      chk("mid_three_words", W'(n_pop - base), W'(3));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("mid_m_valid", W'(bus.m_valid), W'(0));
      chk("mid_m_data", bus.m_data, W'(0));
      chk("mid_rd_count", rd_count, W'(0));
      exp_q.delete();
      for (int i = rd_ptr; i < wr_ptr; i++) exp_q.push_back(mem[i]);
      base = exp_q.size();
      drain(40);
      chk("mid_rd_count_after", rd_count, W'(base));

      // underflow flagged on the beat after a read
      ready = 1'b0;
      push_word(16'h0055);
      #1 chk("uf_rd_en", W'(bus.fifo_rd_en), W'(1));
      tick();
      uf_force = 1'b1;
`ifdef FIFO_READER_CHECK_EN
      void'(exp_q.pop_back());
      tick();
      uf_force = 1'b0;
      chk("uf_err_set", W'(underflow_err), W'(1));
      chk("uf_no_push", W'(bus.m_valid), W'(0));
      tick();
      tick();
      chk("uf_err_sticky", W'(underflow_err), W'(1));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1 chk("uf_err_cleared", W'(underflow_err), W'(0));
`else
      tick();
      uf_force = 1'b0;
      chk("uf_err_zero", W'(underflow_err), W'(0));
      chk("uf_word_kept", W'(bus.m_valid), W'(1));
      chk("uf_word_data", bus.m_data, W'(16'h0055));
      ready = 1'b1;
      drain(10);
      chk("uf_err_still_zero", W'(underflow_err), W'(0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
